// File: rtl/psa_pkg.sv
// Shared definitions for the streaming pattern search block.
// Holds default parameters, the wildcard symbol and the one-hot FSM encoding.
// No logic lives here; everything is imported by the design files.
package psa_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 15;
  localparam int PLEN_W_DEF = 8;
  localparam int RD_LAT_DEF = 2;
  localparam int CNT_W_DEF  = 16;

  // Pattern symbol that matches anything when wildcarding is enabled ('?').
  localparam logic [7:0] WILDCARD = 8'h3F;

  typedef enum logic [6:0] {
    IDLE  = 7'b000_0001,
    CHECK = 7'b000_0010,
    ISSUE = 7'b000_0100,
    WAIT  = 7'b000_1000,
    CMP   = 7'b001_0000,
    EMIT  = 7'b010_0000,
    DONE  = 7'b100_0000
  } state_t;

endpackage

// File: rtl/psa_match_emitter.sv
// Match output register and saturating match counter.
// Latency: match_valid rises the cycle after load; count updates on handshake edge.
// Backpressure: match_valid/match_addr hold until match_ready is seen high.
module psa_match_emitter #(
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              match_ready,
  output logic              match_valid,
  output logic [ADDR_W-1:0] match_addr,
  output logic [CNT_W-1:0]  match_count,
  output logic              fire
);

  assign fire = match_valid & match_ready;

  // Offer register: set when a full match is found, dropped after the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_valid <= 1'b0;
      match_addr  <= '0;
    end else if (load) begin
      match_valid <= 1'b1;
      match_addr  <= load_addr;
    end else if (fire) begin
      match_valid <= 1'b0;
    end
  end

  // Match counter: cleared per search, sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      match_count <= '0;
    end else if (fire && !(&match_count)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pattern_search_stream.sv
// Brute-force search of a pattern in a block held in external read-only memories.
// Latency: RD_LAT+1 cycles per symbol comparison, plus one CHECK cycle per search.
// Backpressure: search stalls in EMIT (no reads) until match_ready accepts the match.
module pattern_search_stream
  import psa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PLEN_W = PLEN_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] pat_base,
  input  logic [PLEN_W-1:0] pat_len,
  input  logic [ADDR_W-1:0] blk_base,
  input  logic [ADDR_W-1:0] blk_len,
  input  logic              mode_all,
  input  logic              wc_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              pat_rd,
  output logic [ADDR_W-1:0] pat_addr,
  input  logic [DATA_W-1:0] pat_data,
  output logic              match_valid,
  output logic [ADDR_W-1:0] match_addr,
  input  logic              match_ready,
  output logic              busy,
  output logic              done,
  output logic              not_found,
  output logic [CNT_W-1:0]  match_count
);

  // Wide enough to compare pattern and block lengths without overflow.
  localparam int LW = ((ADDR_W > PLEN_W) ? ADDR_W : PLEN_W) + 1;
  localparam logic [DATA_W-1:0] WC = DATA_W'(WILDCARD);

  state_t            state, state_d;
  logic [ADDR_W-1:0] s, s_d;
  logic [PLEN_W-1:0] k, k_d;
  logic [2:0]        wcnt, wcnt_d;

  logic [ADDR_W-1:0] pat_base_q, blk_base_q, blk_len_q;
  logic [PLEN_W-1:0] pat_len_q;
  logic              mode_all_q, wc_en_q;

  logic              accept, emit_load, fire;
  logic              sym_match, last_sym, past_end, no_cand;
  logic [LW-1:0]     last_s, s_inc;

  assign accept    = start && (state == IDLE || state == DONE);
  assign last_s    = LW'(blk_len_q) - LW'(pat_len_q);
  assign s_inc     = LW'(s) + LW'(1);
  assign past_end  = s_inc > last_s;
  assign no_cand   = (pat_len_q == '0) || (LW'(pat_len_q) > LW'(blk_len_q));
  assign sym_match = (mem_data == pat_data) || (wc_en_q && (pat_data == WC));
  assign last_sym  = (k == pat_len_q - PLEN_W'(1));

  assign mem_rd    = (state == ISSUE);
  assign pat_rd    = (state == ISSUE);
  assign mem_addr  = blk_base_q + s + ADDR_W'(k);
  assign pat_addr  = pat_base_q + ADDR_W'(k);
  assign busy      = !(state == IDLE || state == DONE);
  assign done      = (state == DONE);
  assign not_found = (state == DONE) && (match_count == '0);

  // Operand capture on an accepted start; cleared so addresses read 0 after reset.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      pat_base_q <= '0;
      pat_len_q  <= '0;
      blk_base_q <= '0;
      blk_len_q  <= '0;
      mode_all_q <= 1'b0;
      wc_en_q    <= 1'b0;
    end else if (accept) begin
      pat_base_q <= pat_base;
      pat_len_q  <= pat_len;
      blk_base_q <= blk_base;
      blk_len_q  <= blk_len;
      mode_all_q <= mode_all;
      wc_en_q    <= wc_en;
    end
  end

  // FSM state and search position registers.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      k     <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_d;
      s     <= s_d;
      k     <= k_d;
      wcnt  <= wcnt_d;
    end
  end

  // Next-state logic: s is the candidate offset, k the symbol within the pattern.
  always_comb begin
    state_d   = state;
    s_d       = s;
    k_d       = k;
    wcnt_d    = wcnt;
    emit_load = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_d = CHECK;
      end
      CHECK: begin
        if (no_cand) begin
          state_d = DONE;
        end else begin
          s_d     = '0;
          k_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = (RD_LAT == 1) ? CMP : WAIT;
      end
      WAIT: begin
        if (wcnt == 3'(RD_LAT - 2)) state_d = CMP;
        else                        wcnt_d  = wcnt + 3'd1;
      end
      CMP: begin
        if (sym_match && !last_sym) begin
          k_d     = k + PLEN_W'(1);
          state_d = ISSUE;
        end else if (sym_match) begin
          emit_load = 1'b1;
          state_d   = EMIT;
        end else begin
          k_d     = '0;
          s_d     = s + ADDR_W'(1);
          state_d = past_end ? DONE : ISSUE;
        end
      end
      EMIT: begin
        if (fire) begin
          if (!mode_all_q || past_end) begin
            state_d = DONE;
          end else begin
            s_d     = s + ADDR_W'(1);
            k_d     = '0;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  psa_match_emitter #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_emit (
    .clk         (CLK100MHZ),
    .reset       (reset),
    .clear       (accept),
    .load        (emit_load),
    .load_addr   (blk_base_q + s),
    .match_ready (match_ready),
    .match_valid (match_valid),
    .match_addr  (match_addr),
    .match_count (match_count),
    .fire        (fire)
  );

endmodule

// File: tb/tb_pattern_search_stream.sv
// Bench for pattern_search_stream: three instances (RD_LAT 2, 1 with a 2-bit counter, 4)
// share stimulus; each has its own latency-accurate memory pipeline.
// Directed table, hand-written backpressure/reset sequences, then random vs a model.
module tb_pattern_search_stream;

  localparam int AW = 15;
  localparam int NL = 3;
  localparam int MEMN = 1 << AW;
  localparam int LATS [NL] = '{2, 1, 4};
  localparam int CWS  [NL] = '{16, 2, 16};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, mode_all, wc_en, match_ready, clr;
  logic [AW-1:0] pat_base, blk_base, blk_len;
  logic [7:0]    pat_len;

  logic          mem_rd      [NL];
  logic [AW-1:0] mem_addr    [NL];
  logic [7:0]    mem_data    [NL];
  logic          pat_rd      [NL];
  logic [AW-1:0] pat_addr    [NL];
  logic [7:0]    pat_data    [NL];
  logic          match_valid [NL];
  logic [AW-1:0] match_addr  [NL];
  logic          busy        [NL];
  logic          done        [NL];
  logic          not_found   [NL];
  logic [15:0]   match_count [NL];

  logic [7:0] bmem [MEMN];
  logic [7:0] pmem [MEMN];
  logic [7:0] bpipe [NL][4];
  logic [7:0] ppipe [NL][4];

  int            rd_cnt [NL];
  int            got_n  [NL];
  logic [AW-1:0] got_a  [NL][16];
  int            viol   [NL];

  for (genvar g = 0; g < NL; g++) begin : lane
    logic [CWS[g]-1:0] mc;
    pattern_search_stream #(
      .DATA_W(8), .ADDR_W(AW), .PLEN_W(8), .RD_LAT(LATS[g]), .CNT_W(CWS[g])
    ) dut (
      .CLK100MHZ(clk), .reset(reset), .start(start),
      .pat_base(pat_base), .pat_len(pat_len), .blk_base(blk_base), .blk_len(blk_len),
      .mode_all(mode_all), .wc_en(wc_en),
      .mem_rd(mem_rd[g]), .mem_addr(mem_addr[g]), .mem_data(mem_data[g]),
      .pat_rd(pat_rd[g]), .pat_addr(pat_addr[g]), .pat_data(pat_data[g]),
      .match_valid(match_valid[g]), .match_addr(match_addr[g]), .match_ready(match_ready),
      .busy(busy[g]), .done(done[g]), .not_found(not_found[g]), .match_count(mc)
    );
    assign match_count[g] = 16'(mc);
    assign mem_data[g]    = bpipe[g][LATS[g]-1];
    assign pat_data[g]    = ppipe[g][LATS[g]-1];
  end

  // External memories with per-lane read latency; idle slots carry junk so mistimed sampling mismatches.
  always @(posedge clk) begin
    for (int g = 0; g < NL; g++) begin
      for (int j = 3; j > 0; j--) begin
        bpipe[g][j] <= bpipe[g][j-1];
        ppipe[g][j] <= ppipe[g][j-1];
      end
      bpipe[g][0] <= mem_rd[g] ? bmem[mem_addr[g]] : 8'hEE;
      ppipe[g][0] <= pat_rd[g] ? pmem[pat_addr[g]] : 8'hDD;
      if (mem_rd[g] !== pat_rd[g]) viol[g] <= viol[g] + 1;
      if (match_valid[g] && !busy[g]) viol[g] <= viol[g] + 1;
      if (clr) begin
        rd_cnt[g] <= 0;
        got_n[g]  <= 0;
      end else begin
        if (mem_rd[g]) rd_cnt[g] <= rd_cnt[g] + 1;
        if (match_valid[g] && match_ready) begin
          if (got_n[g] < 16) got_a[g][got_n[g]] <= match_addr[g];
          got_n[g] <= got_n[g] + 1;
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h", name, g, act, exp);
    end
  endtask

  // Expected results of the current search.
  int            exp_n, exp_na, exp_rd;
  logic [AW-1:0] exp_a [64];

  // Reference: slide the pattern over every legal offset, counting symbol reads as the rules dictate.
  task automatic model(input logic [AW-1:0] pb, input int pl, input logic [AW-1:0] bb,
                       input int bl, input bit mall, input bit wc);
    bit ok;
    logic [7:0] b, p;
    exp_n = 0; exp_rd = 0; exp_na = 0;
    if (pl == 0 || pl > bl) return;
    for (int s = 0; s <= bl - pl; s++) begin
      ok = 1'b1;
      for (int k = 0; k < pl && ok; k++) begin
        b = bmem[(int'(bb) + s + k) % MEMN];
        p = pmem[(int'(pb) + k) % MEMN];
        exp_rd++;
        if (!(b == p || (wc && p == 8'h3F))) ok = 1'b0;
      end
      if (ok) begin
        exp_a[exp_n] = AW'(int'(bb) + s);
        exp_n++;
        exp_na = exp_n;
        if (!mall) return;
      end
    end
  endtask

  task automatic kick(input logic [AW-1:0] pb, input int pl, input logic [AW-1:0] bb,
                      input int bl, input bit mall, input bit wc);
    @(negedge clk);
    pat_base = pb; pat_len = 8'(pl); blk_base = bb; blk_len = AW'(bl);
    mode_all = mall; wc_en = wc; start = 1'b1; clr = 1'b1;
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
  endtask

  task automatic wait_all(input bit rnd, output int edges);
    bit all;
    edges = 0;
    forever begin
      all = 1'b1;
      for (int g = 0; g < NL; g++) if (done[g] !== 1'b1) all = 1'b0;
      if (all || edges > 5000) break;
      match_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      edges++;
    end
    match_ready = 1'b1;
    chk("done_timeout", 0, 32'(edges > 5000), 0);
  endtask

  task automatic compare_all(input string tag);
    int sat, ec;
    for (int g = 0; g < NL; g++) begin
      sat = (1 << CWS[g]) - 1;
      ec  = (exp_n < sat) ? exp_n : sat;
      chk({tag, "_nmatch"}, g, got_n[g], exp_n);
      for (int i = 0; i < exp_na && i < 16 && i < got_n[g]; i++)
        chk({tag, "_addr"}, g, 32'(got_a[g][i]), 32'(exp_a[i]));
      chk({tag, "_count"}, g, 32'(match_count[g]), ec);
      chk({tag, "_notfound"}, g, 32'(not_found[g]), 32'(exp_n == 0));
      chk({tag, "_busy"}, g, 32'(busy[g]), 0);
      chk({tag, "_reads"}, g, rd_cnt[g], exp_rd);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int g = 0; g < NL; g++) begin
      chk({tag, "_busy"}, g, 32'(busy[g]), 0);
      chk({tag, "_done"}, g, 32'(done[g]), 0);
      chk({tag, "_notfound"}, g, 32'(not_found[g]), 0);
      chk({tag, "_mvalid"}, g, 32'(match_valid[g]), 0);
      chk({tag, "_memrd"}, g, 32'(mem_rd[g]), 0);
      chk({tag, "_patrd"}, g, 32'(pat_rd[g]), 0);
      chk({tag, "_count"}, g, 32'(match_count[g]), 0);
      chk({tag, "_memaddr"}, g, 32'(mem_addr[g]), 0);
      chk({tag, "_pataddr"}, g, 32'(pat_addr[g]), 0);
      chk({tag, "_maddr"}, g, 32'(match_addr[g]), 0);
    end
  endtask

  typedef struct {
    logic [AW-1:0] pb; int pl; logic [AW-1:0] bb; int bl; bit mall; bit wc;
    int n; logic [AW-1:0] a0; logic [AW-1:0] a1; int rd; bit quick;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, nw, rd0;
    logic [AW-1:0] rpb, rbb;
    int rpl, rbl;
    bit rmall, rwc;
    logic [7:0] syms [3];

    reset = 1'b1; start = 1'b0; mode_all = 1'b0; wc_en = 1'b0; match_ready = 1'b1; clr = 1'b0;
    pat_base = '0; pat_len = '0; blk_base = '0; blk_len = '0;
    syms[0] = 8'h41; syms[1] = 8'h42; syms[2] = 8'h3F;

    // Block memory: "ABABAB"@0x10, "AAAAAA"@0x20, "AXCAYC"@0x40, "ABABA"@0x7FFE wrapping.
    for (int i = 0; i < 6; i++) bmem[16'h10 + i] = (i % 2 == 0) ? 8'h41 : 8'h42;
    for (int i = 0; i < 6; i++) bmem[16'h20 + i] = 8'h41;
    bmem[16'h40] = "A"; bmem[16'h41] = "X"; bmem[16'h42] = "C";
    bmem[16'h43] = "A"; bmem[16'h44] = "Y"; bmem[16'h45] = "C";
    bmem[16'h7FFE] = "A"; bmem[16'h7FFF] = "B"; bmem[0] = "A"; bmem[1] = "B"; bmem[2] = "A";
    // Pattern memory: "ABAAA"@0, "A?C"@8.
    pmem[0] = "A"; pmem[1] = "B"; pmem[2] = "A"; pmem[3] = "A"; pmem[4] = "A";
    pmem[8] = "A"; pmem[9] = "?"; pmem[10] = "C";

    //            pb       pl  bb        bl mall wc  n  a0        a1        rd quick
    tbl[0] = '{15'h000, 3, 15'h0010, 6, 1, 0, 2, 15'h0010, 15'h0012, 8, 0};
    tbl[1] = '{15'h000, 3, 15'h0010, 6, 0, 0, 1, 15'h0010, 15'h0000, 3, 0};
    tbl[2] = '{15'h000, 0, 15'h0010, 6, 1, 0, 0, 15'h0000, 15'h0000, 0, 1};
    tbl[3] = '{15'h000, 5, 15'h0010, 3, 1, 0, 0, 15'h0000, 15'h0000, 0, 1};
    tbl[4] = '{15'h008, 3, 15'h0040, 6, 1, 1, 2, 15'h0040, 15'h0043, 8, 0};
    tbl[5] = '{15'h008, 3, 15'h0040, 6, 1, 0, 0, 15'h0000, 15'h0000, 6, 0};
    tbl[6] = '{15'h000, 3, 15'h0010, 3, 1, 0, 1, 15'h0010, 15'h0000, 3, 0};
    tbl[7] = '{15'h000, 3, 15'h7FFE, 5, 1, 0, 2, 15'h7FFE, 15'h0000, 7, 0};
    tbl[8] = '{15'h000, 1, 15'h0020, 6, 1, 0, 6, 15'h0020, 15'h0021, 6, 0};

    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    // Directed table.
    for (int t = 0; t < 9; t++) begin
      kick(tbl[t].pb, tbl[t].pl, tbl[t].bb, tbl[t].bl, tbl[t].mall, tbl[t].wc);
      wait_all(1'b0, e);
      if (tbl[t].quick) chk("quick_done_latency", t, 32'(e + 1 <= 2), 1);
      exp_n = tbl[t].n; exp_rd = tbl[t].rd;
      exp_na = (exp_n < 2) ? exp_n : 2;
      exp_a[0] = tbl[t].a0; exp_a[1] = tbl[t].a1;
      compare_all($sformatf("tbl%0d", t));
      for (int g = 0; g < NL; g++) chk("tbl_done", g, 32'(done[g]), 1);
    end

    // Backpressure: match_ready low for 10 cycles while lane 0 offers its match.
    match_ready = 1'b0;
    kick(15'h000, 3, 15'h0010, 6, 0, 0);
    nw = 0;
    while (match_valid[0] !== 1'b1 && nw < 300) begin @(negedge clk); nw++; end
    chk("hold_reach_emit", 0, 32'(match_valid[0]), 1);
    rd0 = rd_cnt[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 0, 32'(match_valid[0]), 1);
      chk("hold_addr", 0, 32'(match_addr[0]), 32'h10);
      chk("hold_count", 0, 32'(match_count[0]), 0);
      chk("hold_reads", 0, rd_cnt[0], rd0);
    end
    match_ready = 1'b1;
    wait_all(1'b0, e);
    exp_n = 1; exp_na = 1; exp_rd = 3; exp_a[0] = 15'h0010;
    compare_all("hold");

    // Reset in WAIT with a simultaneous start, then a fresh search on different data.
    kick(15'h000, 3, 15'h0010, 6, 1, 0);
    nw = 0;
    while (mem_rd[0] !== 1'b1 && nw < 50) begin @(negedge clk); nw++; end
    chk("rst_saw_issue", 0, 32'(mem_rd[0]), 1);
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    pat_base = 15'h008; blk_base = 15'h0040; wc_en = 1'b1;
    @(negedge clk);
    chk_zero("midreset");
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NL; g++) chk("rst_start_ignored", g, 32'(busy[g]), 0);
    kick(15'h008, 3, 15'h0040, 6, 1, 1);
    wait_all(1'b0, e);
    exp_n = 2; exp_na = 2; exp_rd = 8; exp_a[0] = 15'h0040; exp_a[1] = 15'h0043;
    compare_all("postreset");

    // Random searches with wrapping bases and random backpressure against the model.
    for (int it = 0; it < 30; it++) begin
      rpb = AW'($urandom); rbb = AW'($urandom);
      rpl = $urandom_range(0, 5); rbl = $urandom_range(0, 16);
      rmall = 1'($urandom_range(0, 1)); rwc = 1'($urandom_range(0, 1));
      for (int i = 0; i < rbl; i++)
        bmem[(int'(rbb) + i) % MEMN] = ($urandom_range(0, 9) == 0) ? 8'h3F : syms[$urandom_range(0, 1)];
      for (int i = 0; i < rpl; i++)
        pmem[(int'(rpb) + i) % MEMN] = syms[$urandom_range(0, 2)];
      model(rpb, rpl, rbb, rbl, rmall, rwc);
      kick(rpb, rpl, rbb, rbl, rmall, rwc);
      wait_all(1'b1, e);
      compare_all($sformatf("rand%0d", it));
    end

    for (int g = 0; g < NL; g++) chk("protocol_violations", g, viol[g], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_search_stream.md
PATTERN_SEARCH_STREAM -- requirements
Module: pattern_search_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, symbol width in bits.
REQ-002 SHALL have parameter ADDR_W, default 15, block/pattern memory address width.
REQ-003 SHALL have parameter PLEN_W, default 8, pattern length width.
REQ-004 SHALL have parameter RD_LAT, default 2 (legal 1..4): cycles from read issue to valid read data.
REQ-005 SHALL have parameter CNT_W, default 16, match counter width.
REQ-006 SHALL have ports, in order:
- CLK100MHZ  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; operands are sampled in that cycle.
- pat_base  in  ADDR_W  pattern start address.
- pat_len  in  PLEN_W  pattern length in symbols.
- blk_base  in  ADDR_W  block start address.
- blk_len  in  ADDR_W  block length in symbols.
- mode_all  in  1  1 = report all matches; 0 = stop after the first match.
- wc_en  in  1  1 = pattern symbol equal to WILDCARD matches any symbol.
- mem_rd, mem_addr  out  1, ADDR_W  block read strobe and address.
- mem_data  in  DATA_W  block read data.
- pat_rd, pat_addr  out  1, ADDR_W  pattern read strobe and address.
- pat_data  in  DATA_W  pattern read data.
- match_valid, match_addr  out  1, ADDR_W  match stream; match_addr is the absolute start address of the match.
- match_ready  in  1  match stream ready.
- busy, done, not_found  out  1 each  status signals.
- match_count  out  CNT_W  number of matches found.

Function
REQ-007 SHALL implement states IDLE, CHECK, ISSUE, WAIT, CMP, EMIT, DONE.
REQ-008 SHALL, on start in IDLE or DONE, latch all operands, clear match_count, not_found and done, and enter CHECK. start SHALL be ignored in every other state.
REQ-009 SHALL, in CHECK, go to DONE without issuing reads if pat_len==0 or pat_len>blk_len. Otherwise it SHALL set s=0, k=0 and go to ISSUE.
REQ-010 SHALL, in ISSUE, assert mem_rd and pat_rd for exactly one cycle, with mem_addr=blk_base+s+k and pat_addr=pat_base+k. Both sums SHALL wrap modulo 2^ADDR_W.
REQ-011 SHALL sample mem_data and pat_data in CMP, exactly RD_LAT cycles after ISSUE. WAIT SHALL last RD_LAT-1 cycles, so each comparison costs RD_LAT+1 cycles.
REQ-012 SHALL treat a symbol as matching if mem_data==pat_data, or if wc_en==1 and pat_data==WILDCARD.
REQ-013 SHALL, in CMP on a symbol match with k<pat_len-1, increment k and go to ISSUE.
REQ-014 SHALL, in CMP on a symbol match with k==pat_len-1, go to EMIT with match_addr=blk_base+s.
REQ-015 SHALL, in CMP on a mismatch, set k=0 and s=s+1. If s+1>blk_len-pat_len it SHALL go to DONE, else to ISSUE.
REQ-016 SHALL, in EMIT, hold match_valid high with match_addr stable until match_ready is high. In the handshake cycle it SHALL increment match_count, saturating at all-ones.
REQ-017 SHALL, after the EMIT handshake: go to DONE if mode_all==0; otherwise set s=s+1, k=0 and go to ISSUE, or to DONE if s+1>blk_len-pat_len. Overlapping matches SHALL be reported.
REQ-018 SHALL, in DONE, hold done=1 and set not_found=(match_count==0). done SHALL remain high until the next start or reset.
REQ-019 SHALL drive busy=1 in every state except IDLE and DONE.
REQ-020 SHALL never assert mem_rd or pat_rd outside ISSUE.
REQ-021 SHALL hold match_valid low outside EMIT.
REQ-022 SHALL treat the maximum-length search, pat_len==blk_len, as exactly one candidate.

Reset
REQ-023 SHALL, when reset is high at a clock edge in any state including mid-search, enter IDLE.
REQ-024 SHALL, on reset, clear busy, done, not_found, match_valid, mem_rd, pat_rd, match_count, mem_addr, pat_addr and match_addr to 0.
REQ-025 SHALL let reset take priority over start in the same cycle.
REQ-026 SHALL, after reset, discard read data still in flight.

Structure
REQ-027 SHALL take the state encoding (one-hot, 7 bits), WILDCARD (default 8'h3F, truncated/extended to DATA_W) and the default parameter values from shared package psa_pkg.
REQ-028 SHALL contain no memory instance. Block and pattern BRAMs SHALL be external, connected through the read ports.
REQ-029 SHALL contain one natural sub-module, psa_match_emitter, holding the EMIT handshake register and the saturating match counter.

Verification
REQ-030 SHALL be verified with: block "ABABAB" at 0x10, pattern "ABA", mode_all=1 -> match_addr 0x10 then 0x12, match_count=2, not_found=0.
REQ-031 SHALL be verified with: same stimulus, mode_all=0 -> a single match at 0x10, then done, with no further reads issued.
REQ-032 SHALL be verified with: pat_len=0, and separately pat_len=5 with blk_len=3 -> done within 2 cycles of start, not_found=1, mem_rd never asserted.
REQ-033 SHALL be verified with: wc_en=1, pattern "A?C", block "AXCAYC" -> matches at offsets 0 and 3. With wc_en=0 -> not_found=1.
REQ-034 SHALL be verified with: match_ready held low for 10 cycles during EMIT -> match_valid and match_addr stable, no reads issued, match_count incremented once.
REQ-035 SHALL be verified with: reset asserted in WAIT, then a new start -> IDLE on the next edge, all outputs 0, and the new search's results unaffected by stale read data. Repeat with RD_LAT=1 and RD_LAT=4.
